// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: registered clk_out, aligned tick strobe and
// glitch-free divisor update on full-period boundaries. Optional status ports via CLK_DIV_CTRL_STATUS_EN.
module clk_div_ctrl #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 10
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [1:0]       state
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    output logic [15:0]      period_cnt,
    output logic [CNT_W-1:0] div_cur
`endif
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_active;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_cfg_err;
    logic             r_cfg_ready;

    logic             w_xfer;
    logic             w_cfg_zero;
    logic             w_last;
    logic             w_rise;
    logic             w_fall;
    logic             w_counting;
    logic             w_tick_set;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clk_nxt;

    assign w_xfer     = cfg_valid && r_cfg_ready;
    assign w_cfg_zero = (cfg_div == '0);
    assign w_last     = (r_cnt == r_div_active - ONE);
    assign w_rise     = w_last && !r_clk_out;
    assign w_fall     = w_last && r_clk_out;
    assign w_cnt_nxt  = w_last ? '0 : r_cnt + ONE;
    assign w_clk_nxt  = w_last ? ~r_clk_out : r_clk_out;

    // A halting clock that is already low stops at once, so it never starts a runt high phase.
    assign w_counting = (r_state == ST_RUN) || (r_state == ST_PEND) ||
                        ((r_state == ST_HALT) && (en || r_clk_out));
    assign w_tick_set = w_counting && w_rise;

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, so branch order cannot create races.
            r_state      <= ST_STOP;
            r_cnt        <= '0;
            r_div_active <= DIV_RST;
            r_div_pend   <= DIV_RST;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_cfg_ready  <= 1'b1;
        end else begin
            r_tick    <= w_tick_set;
            r_cfg_err <= w_xfer && w_cfg_zero;
            case (r_state)
                ST_STOP: begin
                    r_cnt       <= '0;
                    r_clk_out   <= 1'b0;
                    r_cfg_ready <= 1'b1;
                    if (w_xfer && !w_cfg_zero) r_div_active <= cfg_div;
                    if (en) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_cnt     <= w_cnt_nxt;
                    r_clk_out <= w_clk_nxt;
                    if (w_xfer && !w_cfg_zero) begin
                        r_div_pend  <= cfg_div;
                        r_state     <= ST_PEND;
                        r_cfg_ready <= 1'b0;
                    end else if (!en) begin
                        r_state     <= ST_HALT;
                        r_cfg_ready <= 1'b0;
                    end
                end
                ST_PEND: begin
                    r_cnt     <= w_cnt_nxt;
                    r_clk_out <= w_clk_nxt;
                    if (w_fall) begin
                        r_div_active <= r_div_pend;
                        r_cfg_ready  <= 1'b1;
                        r_state      <= en ? ST_RUN : ST_STOP;
                    end
                end
                ST_HALT: begin
                    if (en) begin
                        r_cnt       <= w_cnt_nxt;
                        r_clk_out   <= w_clk_nxt;
                        r_cfg_ready <= 1'b1;
                        r_state     <= ST_RUN;
                    end else if (!r_clk_out) begin
                        r_cnt       <= '0;
                        r_cfg_ready <= 1'b1;
                        r_state     <= ST_STOP;
                    end else begin
                        r_cnt     <= w_cnt_nxt;
                        r_clk_out <= w_clk_nxt;
                        if (w_fall) begin
                            r_cfg_ready <= 1'b1;
                            r_state     <= ST_STOP;
                        end
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign state     = r_state;

`ifdef CLK_DIV_CTRL_STATUS_EN
    logic [15:0] r_period_cnt;

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_tick_set) begin
            r_period_cnt <= r_period_cnt + 16'd1;
        end
    end

    assign period_cnt = r_period_cnt;
    assign div_cur    = r_div_active;
`endif

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime-programmable clock-divider controller.
- Generates a divided clock level and an aligned tick strobe from clk_100MHz.
- Accepts divisor changes through a valid/ready handshake and applies them only at a full-period boundary, so the output never glitches.
- Starts and stops the divided clock cleanly; clk_out always parks low.

Parameters:
- CNT_W, 16, width of divisor and internal counter.
- DEF_DIV, 10, half-period divisor loaded at reset (10 gives 5 MHz out).

Ports:
- clk_100MHz  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run request; level-sensitive.
- cfg_valid  input  1  new divisor offered.
- cfg_div  input  CNT_W  half-period length in clk_100MHz cycles; must be >=1.
- cfg_ready  output  1  controller can accept cfg.
- cfg_err  output  1  one-cycle pulse: accepted cfg_div was 0 and was discarded.
- clk_out  output  1  divided clock, registered; period = 2*div_active cycles.
- tick  output  1  one-cycle pulse in the cycle clk_out goes 0->1.
- state  output  2  0=STOP, 1=RUN, 2=PEND, 3=HALT.

Behaviour:
- Clock and reset: one clock, clk_100MHz. rst is synchronous and active-high.
- Reset values:
  - Outputs: clk_out=0, tick=0, cfg_err=0, cfg_ready=1, state=STOP.
  - Internal: div_active=DEF_DIV, counter=0.
- Handshake: a transfer occurs when cfg_valid && cfg_ready at the clock edge.
  - cfg_div==0: transfer still completes. cfg_err=1 next cycle, nothing else changes.
- Counter (RUN/PEND/HALT):
  - Increments each cycle.
  - At counter==div_active-1: clk_out toggles, counter<=0.
  - tick=1 in the same cycle clk_out becomes 1. tick is 0 in every other cycle.
- STOP:
  - clk_out=0, counter held at 0, cfg_ready=1.
  - Accepted cfg loads div_active directly.
  - en=1 -> RUN next cycle; first rising toggle after div_active RUN cycles.
  - cfg accepted in the same cycle as en rising: the new value is used for the first period.
- RUN:
  - Accepted nonzero cfg -> stored in div_pend, state PEND, cfg_ready=0.
  - en=0 -> HALT.
- PEND:
  - At the next 1->0 toggle (full-period end): div_active<=div_pend, counter<=0, cfg_ready=1.
  - Then RUN if en=1, STOP if en=0.
  - en=0 while in PEND does not abandon the pending value.
- HALT:
  - clk_out=0 on entry -> STOP next cycle; the low phase is truncated, no runt high.
  - clk_out=1 -> keep counting, go to STOP at the 1->0 toggle.
  - en=1 during HALT -> back to RUN with no counter or clk_out disturbance.
  - cfg_ready=0 in HALT.
- Simultaneous cfg accept and toggle in RUN: the toggle uses the old divisor. The new one applies at the next 1->0 toggle, not the current one.
- div_active=1: clk_out toggles every cycle (50 MHz).
- Counter width: comparisons are unsigned on CNT_W bits; max half-period is 2^CNT_W-1.
- rst mid-operation (any state, including PEND): all outputs return to reset values next cycle and div_pend is discarded.

Optional Feature:
- Macro: CLK_DIV_CTRL_STATUS_EN.
- Defined:
  - Adds output period_cnt [15:0], reset 0.
  - Increments on every tick and wraps 0xFFFF->0.
  - Adds output div_cur [CNT_W-1:0] mirroring div_active.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, en=1, DEF_DIV=10 -> first tick 10 cycles after RUN entry, then tick every 20 cycles. clk_out high for 10, low for 10.
- STOP, cfg_div=1 accepted, en=1 -> clk_out toggles every cycle. tick every 2 cycles.
- RUN div=10, cfg_div=4 offered 3 cycles after a rising toggle:
  - cfg_ready drops and state=PEND.
  - Current high phase (10) completes, then switch at the falling edge.
  - Subsequent halves are 4 cycles. cfg_ready=1 in the switch cycle.
- RUN div=10, en dropped 2 cycles into a high phase -> state HALT, high phase completes its 10 cycles, clk_out=0, state STOP. No further ticks.
- cfg_div=0 offered in RUN -> cfg_err pulses once, div_active unchanged, period stays 20.
- rst asserted while in PEND with div_pend=7 -> next cycle state=STOP, clk_out=0, cfg_ready=1. After en=1 the period is 20 (DEF_DIV), not 14.
